// File: rtl/trace_if.sv
// Commit-trace bus: retire-side capture port plus first-word-fall-through drain port.
// Latency: n/a (wiring only).
// Backpressure: drain side uses rd_valid/rd_ready; commit side cannot be stalled.
interface trace_if #(
    parameter int PC_WIDTH       = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int STAMP_WIDTH    = 16
);
    logic                      commit_valid;
    logic [PC_WIDTH-1:0]       commit_pc;
    logic                      commit_we;
    logic [REG_ADDR_WIDTH-1:0] commit_rd;
    logic [DATA_WIDTH-1:0]     commit_wdata;

    logic                      rd_valid;
    logic                      rd_ready;
    logic [PC_WIDTH-1:0]       rd_pc;
    logic                      rd_we;
    logic [REG_ADDR_WIDTH-1:0] rd_rd;
    logic [DATA_WIDTH-1:0]     rd_wdata;
    logic [STAMP_WIDTH-1:0]    rd_stamp;

    modport master (
        output commit_valid, commit_pc, commit_we, commit_rd, commit_wdata, rd_ready,
        input  rd_valid, rd_pc, rd_we, rd_rd, rd_wdata, rd_stamp
    );

    modport slave (
        input  commit_valid, commit_pc, commit_we, commit_rd, commit_wdata, rd_ready,
        output rd_valid, rd_pc, rd_we, rd_rd, rd_wdata, rd_stamp
    );
endinterface

// File: rtl/trace_capture_unit.sv
// Commit-trace buffer: captures retired instructions in fill-stop or ring mode with PC trigger.
// Latency: a captured entry is visible the cycle after its commit; drain head is fall-through.
// Backpressure: head holds while rd_ready is low; commits are never stalled, only dropped when not capturing.
module trace_capture_unit #(
    parameter int PC_WIDTH       = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DEPTH          = 8,
    parameter int STAMP_WIDTH    = 16,
    localparam int AW            = $clog2(DEPTH),
    localparam int CW            = AW + 1
) (
    input  logic                clk,
    input  logic                reset,
    trace_if.slave              tif,
    input  logic                cfg_mode,
    input  logic                cfg_trig_en,
    input  logic [PC_WIDTH-1:0] cfg_trig_pc,
    input  logic [CW-1:0]       cfg_post_count,
    input  logic                arm,
    input  logic                stop,
    output logic [1:0]          state,
    output logic [CW-1:0]       count,
    output logic                overflow,
    output logic                triggered
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]       pc;
        logic                      we;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [STAMP_WIDTH-1:0]    stamp;
    } entry_t;

    entry_t                 mem [DEPTH];
    state_t                 st_q, st_d;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          cnt_q, post_q, post_d;
    logic                   ovf_q, trig_q;
    logic [STAMP_WIDTH-1:0] stamp_q;
    logic                   capture, hit, pop, full;

    always_comb begin
        st_d    = st_q;
        post_d  = post_q;
        capture = 1'b0;
        hit     = 1'b0;
        pop     = 1'b0;
        full    = (cnt_q == CW'(DEPTH));
        unique case (st_q)
            S_IDLE: begin
            end
            S_ARMED: begin
                capture = tif.commit_valid;
                hit     = capture && cfg_trig_en && (tif.commit_pc == cfg_trig_pc);
                if (hit) begin
                    post_d = cfg_post_count;
                    st_d   = (cfg_post_count == '0) ? S_DONE : S_POST;
                end
                // Fill-stop full wins over entering POST on the same edge.
                if (capture && !cfg_mode && cnt_q == CW'(DEPTH - 1)) st_d = S_DONE;
                if (stop) st_d = S_DONE;
            end
            S_POST: begin
                capture = tif.commit_valid;
                if (capture) begin
                    post_d = post_q - 1'b1;
                    if (post_q == CW'(1)) st_d = S_DONE;
                    if (!cfg_mode && cnt_q == CW'(DEPTH - 1)) st_d = S_DONE;
                end
                if (stop) st_d = S_DONE;
            end
            S_DONE: begin
                pop = (cnt_q != '0) && tif.rd_ready;
                if (cnt_q == '0 || (pop && cnt_q == CW'(1))) st_d = S_IDLE;
            end
        endcase
        if (arm) st_d = S_ARMED;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q     <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            post_q   <= '0;
            ovf_q    <= 1'b0;
            trig_q   <= 1'b0;
            stamp_q  <= '0;
        end else begin
            st_q    <= st_d;
            post_q  <= post_d;
            stamp_q <= stamp_q + 1'b1;
            if (arm) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                ovf_q    <= 1'b0;
                trig_q   <= 1'b0;
            end else begin
                if (capture) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    // A capture into a full buffer drops the oldest entry.
                    if (full) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        ovf_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                if (hit) trig_q <= 1'b1;
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    cnt_q    <= cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture && !arm) begin
            mem[wr_ptr_q] <= '{pc: tif.commit_pc, we: tif.commit_we, rd: tif.commit_rd,
                               wdata: tif.commit_wdata, stamp: stamp_q};
        end
    end

    assign tif.rd_valid = (st_q == S_DONE) && (cnt_q != '0);
    assign tif.rd_pc    = mem[rd_ptr_q].pc;
    assign tif.rd_we    = mem[rd_ptr_q].we;
    assign tif.rd_rd    = mem[rd_ptr_q].rd;
    assign tif.rd_wdata = mem[rd_ptr_q].wdata;
    assign tif.rd_stamp = mem[rd_ptr_q].stamp;

    assign state     = st_q;
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    assign triggered = trig_q;
endmodule

// File: tb/tb_trace_capture_unit.sv
module tb_trace_capture_unit;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_mode, cfg_trig_en, arm, stop;
    logic [31:0] cfg_trig_pc;
    logic [3:0]  cfg_post_count;
    logic [1:0]  state;
    logic [3:0]  count;
    logic        overflow, triggered;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_if #(.PC_WIDTH(32), .DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .STAMP_WIDTH(16)) tif ();

    trace_capture_unit #(.PC_WIDTH(32), .DATA_WIDTH(32), .REG_ADDR_WIDTH(4),
                         .DEPTH(DEPTH), .STAMP_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .tif(tif),
        .cfg_mode(cfg_mode), .cfg_trig_en(cfg_trig_en), .cfg_trig_pc(cfg_trig_pc),
        .cfg_post_count(cfg_post_count), .arm(arm), .stop(stop),
        .state(state), .count(count), .overflow(overflow), .triggered(triggered)
    );

    // Reference model: trace is a queue of captured records, oldest first.
    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [3:0]  rd;
        logic [31:0] wdata;
        logic [15:0] stamp;
    } ent_t;

    ent_t        q[$];
    logic [1:0]  m_state;
    logic        m_ovf, m_trig;
    int          m_post;
    logic [15:0] m_stamp;

    task automatic model_reset();
        q.delete();
        m_state = 2'd0; m_ovf = 1'b0; m_trig = 1'b0; m_post = 0; m_stamp = '0;
    endtask

    task automatic model_edge();
        bit   cap;
        ent_t e;
        cap = tif.commit_valid && (m_state == 2'd1 || m_state == 2'd2);
        if (arm) begin
            q.delete(); m_ovf = 1'b0; m_trig = 1'b0; m_state = 2'd1;
        end else if (m_state == 2'd1 || m_state == 2'd2) begin
            if (cap) begin
                e = '{tif.commit_pc, tif.commit_we, tif.commit_rd, tif.commit_wdata, m_stamp};
                if (q.size() == DEPTH) begin void'(q.pop_front()); m_ovf = 1'b1; end
                q.push_back(e);
            end
            if (m_state == 2'd1) begin
                if (cap && cfg_trig_en && tif.commit_pc == cfg_trig_pc) begin
                    m_trig = 1'b1; m_post = int'(cfg_post_count);
                    m_state = (m_post == 0) ? 2'd3 : 2'd2;
                end
            end else if (cap) begin
                m_post--;
                if (m_post == 0) m_state = 2'd3;
            end
            if (cap && !cfg_mode && q.size() == DEPTH) m_state = 2'd3;
            if (stop) m_state = 2'd3;
        end else if (m_state == 2'd3) begin
            if (q.size() == 0) m_state = 2'd0;
            else if (tif.rd_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) m_state = 2'd0;
            end
        end
        m_stamp++;
    endtask

    // Advance one clock; returns at the following falling edge with pulses cleared.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        tif.commit_valid = 1'b0; arm = 1'b0; stop = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc);
        tif.commit_valid = 1'b1;
        tif.commit_pc    = pc;
        tif.commit_we    = 1'($urandom_range(0, 1));
        tif.commit_rd    = 4'($urandom);
        tif.commit_wdata = $urandom;
    endtask

    task automatic test_reset();
        if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end checks++;
        if (tif.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b exp 0", tif.rd_valid); end checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b exp 0", overflow); end checks++;
        if (triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered: got %b exp 0", triggered); end checks++;
    endtask

    task automatic test_fill_stop();
        cfg_mode = 1'b0; cfg_trig_en = 1'b0; tif.rd_ready = 1'b0;
        arm = 1'b1; tick();
        for (int i = 0; i < 10; i++) begin
            commit(32'(4 * i)); tick();
            if (state !== m_state) begin errors++; $display("FAIL fill_state[%0d]: got %0d exp %0d", i, state, m_state); end checks++;
        end
        if (state !== 2'd3 || count !== 4'd8 || overflow !== 1'b0) begin
            errors++; $display("FAIL fill_done: got st=%0d cnt=%0d ovf=%b exp st=3 cnt=8 ovf=0", state, count, overflow);
        end checks++;
        for (int i = 0; i < 8; i++) begin
            if (tif.rd_valid !== 1'b1 || tif.rd_pc !== 32'(4 * i)) begin
                errors++; $display("FAIL fill_drain[%0d]: got v=%b pc=%h exp v=1 pc=%h", i, tif.rd_valid, tif.rd_pc, 4 * i);
            end checks++;
            tif.rd_ready = 1'b1; tick();
        end
        tif.rd_ready = 1'b0;
        if (state !== 2'd0 || tif.rd_valid !== 1'b0) begin errors++; $display("FAIL fill_idle: got st=%0d v=%b exp st=0 v=0", state, tif.rd_valid); end checks++;
    endtask

    task automatic test_ring();
        cfg_mode = 1'b1; cfg_trig_en = 1'b0; tif.rd_ready = 1'b0;
        arm = 1'b1; tick();
        for (int i = 0; i < 11; i++) begin commit(32'(4 * i)); tick(); end
        stop = 1'b1; tick();
        if (state !== 2'd3 || count !== 4'd8 || overflow !== 1'b1) begin
            errors++; $display("FAIL ring_done: got st=%0d cnt=%0d ovf=%b exp st=3 cnt=8 ovf=1", state, count, overflow);
        end checks++;
        for (int i = 0; i < 8; i++) begin
            if (tif.rd_pc !== 32'(12 + 4 * i) || tif.rd_stamp !== q[0].stamp) begin
                errors++; $display("FAIL ring_drain[%0d]: got pc=%h st=%h exp pc=%h st=%h", i, tif.rd_pc, tif.rd_stamp, 12 + 4 * i, q[0].stamp);
            end checks++;
            tif.rd_ready = 1'b1; tick();
        end
        tif.rd_ready = 1'b0;
    endtask

    task automatic test_trigger_post();
        logic [31:0] got[$];
        cfg_mode = 1'b1; cfg_trig_en = 1'b1; cfg_trig_pc = 32'h40; cfg_post_count = 4'd2; tif.rd_ready = 1'b0;
        arm = 1'b1; tick();
        for (int pc = 'h30; pc <= 'h50; pc += 4) begin commit(32'(pc)); tick(); end
        if (state !== 2'd3 || triggered !== 1'b1 || count !== 4'd7) begin
            errors++; $display("FAIL trig_done: got st=%0d trig=%b cnt=%0d exp st=3 trig=1 cnt=7", state, triggered, count);
        end checks++;
        for (int i = 0; i < 12 && tif.rd_valid; i++) begin got.push_back(tif.rd_pc); tif.rd_ready = 1'b1; tick(); end
        tif.rd_ready = 1'b0;
        if (got.size() != 7 || got[4] !== 32'h40 || got[5] !== 32'h44 || got[6] !== 32'h48) begin
            errors++; $display("FAIL trig_tail: got n=%0d exp n=7 tail 40 44 48", got.size());
        end checks++;
    endtask

    task automatic test_post_zero();
        logic [15:0] exp_stamp;
        cfg_mode = 1'b0; cfg_trig_en = 1'b1; cfg_trig_pc = 32'h100; cfg_post_count = 4'd0;
        arm = 1'b1; tick();
        exp_stamp = m_stamp;
        commit(32'h100); tick();
        if (state !== 2'd3 || count !== 4'd1 || tif.rd_pc !== 32'h100 || tif.rd_stamp !== exp_stamp) begin
            errors++; $display("FAIL post_zero: got st=%0d cnt=%0d pc=%h st=%h exp st=3 cnt=1 pc=100 st=%h",
                               state, count, tif.rd_pc, tif.rd_stamp, exp_stamp);
        end checks++;
        tif.rd_ready = 1'b1; tick(); tif.rd_ready = 1'b0;
        if (state !== 2'd0) begin errors++; $display("FAIL post_zero_idle: got %0d exp 0", state); end checks++;
    endtask

    task automatic test_backpressure();
        cfg_mode = 1'b0; cfg_trig_en = 1'b0; tif.rd_ready = 1'b0;
        arm = 1'b1; tick();
        commit(32'h200); tick();
        commit(32'h204); tick();
        commit(32'h208); stop = 1'b1; tick();
        tif.rd_ready = 1'b1; tick();
        tif.rd_ready = 1'b0; tick(); tick();
        if (tif.rd_pc !== 32'h204 || count !== 4'd2) begin errors++; $display("FAIL bp_hold: got pc=%h cnt=%0d exp pc=204 cnt=2", tif.rd_pc, count); end checks++;
        tif.rd_ready = 1'b1; tick(); tif.rd_ready = 1'b0;
        if (tif.rd_pc !== 32'h208 || count !== 4'd1) begin errors++; $display("FAIL bp_pops: got pc=%h cnt=%0d exp pc=208 cnt=1", tif.rd_pc, count); end checks++;
        tif.rd_ready = 1'b1; tick(); tif.rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid_post();
        cfg_mode = 1'b0; cfg_trig_en = 1'b1; cfg_trig_pc = 32'h300; cfg_post_count = 4'd4;
        arm = 1'b1; tick();
        commit(32'h300); tick();
        commit(32'h304); tick();
        if (state !== 2'd2 || triggered !== 1'b1) begin errors++; $display("FAIL mid_post: got st=%0d trig=%b exp st=2 trig=1", state, triggered); end checks++;
        #2 reset = 1'b0;
        #1;
        if (state !== 2'd0 || count !== 4'd0 || triggered !== 1'b0 || tif.rd_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: got st=%0d cnt=%0d trig=%b v=%b exp all 0", state, count, triggered, tif.rd_valid);
        end checks++;
        model_reset();
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_arm_stop();
        arm = 1'b1; stop = 1'b1; tick();
        if (state !== 2'd1 || count !== 4'd0) begin errors++; $display("FAIL arm_stop: got st=%0d cnt=%0d exp st=1 cnt=0", state, count); end checks++;
        stop = 1'b1; tick();
        if (state !== 2'd3 || tif.rd_valid !== 1'b0) begin errors++; $display("FAIL empty_done: got st=%0d v=%b exp st=3 v=0", state, tif.rd_valid); end checks++;
        tick();
        if (state !== 2'd0) begin errors++; $display("FAIL empty_idle: got %0d exp 0", state); end checks++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            cfg_mode = 1'($urandom_range(0, 1));
            cfg_trig_en = 1'($urandom_range(0, 1));
            cfg_trig_pc = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            cfg_post_count = 4'($urandom_range(0, 8));
            arm = 1'b1; tick();
            n = 0;
            while (m_state != 2'd0 && n < 300) begin
                if ($urandom_range(0, 2) != 0) commit(32'h1000 + 32'(4 * $urandom_range(0, 7)));
                stop = (n > 40) || ($urandom_range(0, 29) == 0);
                tif.rd_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
                if (state !== m_state || count !== 4'(q.size()) || overflow !== m_ovf || triggered !== m_trig) begin
                    errors++; $display("FAIL rnd_status[%0d.%0d]: got st=%0d cnt=%0d ovf=%b trig=%b exp st=%0d cnt=%0d ovf=%b trig=%b",
                                       it, n, state, count, overflow, triggered, m_state, q.size(), m_ovf, m_trig);
                end checks++;
                if (m_state == 2'd3 && q.size() != 0) begin
                    if (tif.rd_valid !== 1'b1 || tif.rd_pc !== q[0].pc || tif.rd_we !== q[0].we || tif.rd_rd !== q[0].rd ||
                        tif.rd_wdata !== q[0].wdata || tif.rd_stamp !== q[0].stamp) begin
                        errors++; $display("FAIL rnd_head[%0d.%0d]: got v=%b pc=%h d=%h st=%h exp v=1 pc=%h d=%h st=%h", it, n,
                                           tif.rd_valid, tif.rd_pc, tif.rd_wdata, tif.rd_stamp, q[0].pc, q[0].wdata, q[0].stamp);
                    end checks++;
                end else begin
                    if (tif.rd_valid !== 1'b0) begin errors++; $display("FAIL rnd_valid[%0d.%0d]: got 1 exp 0", it, n); end checks++;
                end
            end
            if (m_state != 2'd0) begin errors++; $display("FAIL rnd_timeout[%0d]: model never returned to IDLE", it); end checks++;
            tif.rd_ready = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0;
        cfg_mode = 1'b0; cfg_trig_en = 1'b0; cfg_trig_pc = '0; cfg_post_count = '0;
        arm = 1'b0; stop = 1'b0;
        tif.commit_valid = 1'b0; tif.commit_pc = '0; tif.commit_we = 1'b0;
        tif.commit_rd = '0; tif.commit_wdata = '0; tif.rd_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_fill_stop();
        test_ring();
        test_trigger_post();
        test_post_zero();
        test_backpressure();
        test_reset_mid_post();
        test_arm_stop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
